// File: rtl/out_fifo_bank_if.sv
// Handshake/data bundle between the AXI read-slave side and the four-lane output FIFO bank.
// master drives push/pop requests; slave is the FIFO bank itself.
interface out_fifo_bank_if #(
    parameter int DATA_W = 32
);
    logic              push;
    logic [1:0]        push_sel;
    logic [DATA_W-1:0] push_data;
    logic              out_fifo_pop;
    logic [1:0]        out_fifo_pop_sel;
    logic              out_fifo_empty;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [3:0]        lane_full;
    logic [3:0]        lane_empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, push_sel, push_data, out_fifo_pop, out_fifo_pop_sel,
        input  out_fifo_empty, rd_data, rd_valid, lane_full, lane_empty, overflow, underflow
    );

    modport slave (
        input  push, push_sel, push_data, out_fifo_pop, out_fifo_pop_sel,
        output out_fifo_empty, rd_data, rd_valid, lane_full, lane_empty, overflow, underflow
    );
endinterface

// File: rtl/out_fifo_bank.sv
// Four independent output FIFO lanes sharing one push port and one registered pop port.
// Full/empty come from registered counts, so same-cycle push/pop decisions use pre-edge state.
module out_fifo_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic            clk,
    input  logic            reset,
    out_fifo_bank_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]        full_vec;
    logic [3:0]        empty_vec;
    logic [3:0]        push_ok;
    logic [3:0]        pop_ok;
    logic [DATA_W-1:0] head_word [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [DATA_W-1:0] mem [DEPTH];
            logic [AW-1:0]     wr_ptr_reg;
            logic [AW-1:0]     rd_ptr_reg;
            logic [CW-1:0]     count_reg;
            logic [CW-1:0]     count_next;

            assign full_vec[gi]  = (count_reg == CW'(DEPTH));
            assign empty_vec[gi] = (count_reg == '0);
            assign push_ok[gi]   = bus.push && (bus.push_sel == 2'(gi)) && !full_vec[gi];
            assign pop_ok[gi]    = bus.out_fifo_pop && (bus.out_fifo_pop_sel == 2'(gi)) && !empty_vec[gi];
            assign head_word[gi] = mem[rd_ptr_reg];

            always_comb begin
                count_next = count_reg;
                case ({push_ok[gi], pop_ok[gi]})
                    2'b10:   count_next = count_reg + CW'(1);
                    2'b01:   count_next = count_reg - CW'(1);
                    default: count_next = count_reg;
                endcase
            end

            // Pointers are exactly log2(DEPTH) bits, so wrap modulo DEPTH comes for free.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push_ok[gi]) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    if (pop_ok[gi])  rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    count_reg <= count_next;
                end
            end

            always_ff @(posedge clk) begin
                if (push_ok[gi]) mem[wr_ptr_reg] <= bus.push_data;
            end
        end
    endgenerate

    logic              pop_any;
    logic              overflow_next;
    logic              underflow_next;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    assign pop_any        = |pop_ok;
    assign overflow_next  = bus.push && full_vec[bus.push_sel];
    assign underflow_next = bus.out_fifo_pop && empty_vec[bus.out_fifo_pop_sel];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            rd_valid_reg  <= pop_any;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            if (pop_any) rd_data_reg <= head_word[bus.out_fifo_pop_sel];
        end
    end

    assign bus.out_fifo_empty = empty_vec[bus.out_fifo_pop_sel];
    assign bus.rd_data        = rd_data_reg;
    assign bus.rd_valid       = rd_valid_reg;
    assign bus.lane_full      = full_vec;
    assign bus.lane_empty     = empty_vec;
    assign bus.overflow       = overflow_reg;
    assign bus.underflow      = underflow_reg;
endmodule

// File: tb/tb_out_fifo_bank.sv
// Randomised and directed bench for out_fifo_bank against a queue-per-lane reference model.
module tb_out_fifo_bank;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;

    logic clk;
    logic reset;
    out_fifo_bank_if #(.DATA_W(DATA_W)) bus ();

    out_fifo_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    logic [DATA_W-1:0] q [4][$];
    logic [DATA_W-1:0] exp_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_full();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (q[i].size() == DEPTH);
        return v;
    endfunction

    function automatic logic [3:0] exp_empty();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (q[i].size() == 0);
        return v;
    endfunction

    // One clock of stimulus; entered and left at posedge+1.
    task automatic step(input bit p, input logic [1:0] ps, input logic [DATA_W-1:0] d,
                        input bit o, input logic [1:0] os);
        bit e_ovf, e_unf, e_val;
        bus.push = p; bus.push_sel = ps; bus.push_data = d;
        bus.out_fifo_pop = o; bus.out_fifo_pop_sel = os;
        #1;
        chk("out_fifo_empty", 64'(bus.out_fifo_empty), 64'(q[os].size() == 0));
        e_ovf = p && (q[ps].size() == DEPTH);
        e_unf = o && (q[os].size() == 0);
        e_val = o && !e_unf;
        if (e_val) exp_rd = q[os].pop_front();
        if (p && !e_ovf) q[ps].push_back(d);
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d push=%0b sel=%0d data=%0h pop=%0b sel=%0d -> rd_valid=%0b rd_data=%0h ovf=%0b unf=%0b",
                 txn, p, ps, d, o, os, bus.rd_valid, bus.rd_data, bus.overflow, bus.underflow);
        chk("rd_valid",   64'(bus.rd_valid),   64'(e_val));
        chk("rd_data",    64'(bus.rd_data),    64'(exp_rd));
        chk("overflow",   64'(bus.overflow),   64'(e_ovf));
        chk("underflow",  64'(bus.underflow),  64'(e_unf));
        chk("lane_full",  64'(bus.lane_full),  64'(exp_full()));
        chk("lane_empty", 64'(bus.lane_empty), 64'(exp_empty()));
    endtask

    task automatic idle_outputs_check(input string tag);
        chk({tag, "_rd_valid"},   64'(bus.rd_valid),   64'(0));
        chk({tag, "_overflow"},   64'(bus.overflow),   64'(0));
        chk({tag, "_underflow"},  64'(bus.underflow),  64'(0));
        chk({tag, "_rd_data"},    64'(bus.rd_data),    64'(0));
        chk({tag, "_lane_empty"}, 64'(bus.lane_empty), 64'(4'hF));
        chk({tag, "_lane_full"},  64'(bus.lane_full),  64'(4'h0));
        for (int s = 0; s < 4; s++) begin
            bus.out_fifo_pop_sel = 2'(s);
            #1;
            chk({tag, "_out_fifo_empty"}, 64'(bus.out_fifo_empty), 64'(1));
        end
    endtask

    // Asynchronous reset applied mid-cycle while push/pop stay requested.
    task automatic mid_reset();
        bus.push = 1'b1; bus.push_sel = 2'd0; bus.push_data = 32'hDEAD;
        bus.out_fifo_pop = 1'b1; bus.out_fifo_pop_sel = 2'd2;
        #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) q[i].delete();
        exp_rd = '0;
        idle_outputs_check("rst_async");
        bus.out_fifo_pop_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        idle_outputs_check("rst_held");
        bus.push = 1'b0; bus.out_fifo_pop = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.push = 1'b0; bus.push_sel = '0; bus.push_data = '0;
        bus.out_fifo_pop = 1'b0; bus.out_fifo_pop_sel = '0;
        exp_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        idle_outputs_check("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic order on lane 1
        step(1, 2'd1, 32'hA1, 0, 2'd0);
        step(1, 2'd1, 32'hA2, 0, 2'd0);
        step(1, 2'd1, 32'hA3, 0, 2'd0);
        repeat (3) step(0, 2'd0, 32'h0, 1, 2'd1);

        // Fill lane 2, overflow, drain, then one extra pop
        for (int i = 0; i <= DEPTH; i++) step(1, 2'd2, 32'h200 + 32'(i), 0, 2'd0);
        for (int i = 0; i <= DEPTH; i++) step(0, 2'd0, 32'h0, 1, 2'd2);

        // Full lane: push refused, pop accepted in the same cycle
        for (int i = 0; i < DEPTH; i++) step(1, 2'd2, 32'h300 + 32'(i), 0, 2'd0);
        step(1, 2'd2, 32'h3FF, 1, 2'd2);
        for (int i = 0; i < DEPTH; i++) step(0, 2'd0, 32'h0, 1, 2'd2);

        // Empty lane 3 pop
        step(0, 2'd0, 32'h0, 1, 2'd3);

        // Empty lane 0: push accepted, pop refused; then pop returns the word
        step(1, 2'd0, 32'h55, 1, 2'd0);
        step(0, 2'd0, 32'h0, 1, 2'd0);

        // Wrap-around on lane 0 with count held at 3
        for (int i = 0; i < 3; i++) step(1, 2'd0, 32'h400 + 32'(i), 0, 2'd0);
        for (int i = 0; i < 3 * DEPTH; i++) step(1, 2'd0, $urandom, 1, 2'd0);
        for (int i = 0; i < 3; i++) step(0, 2'd0, 32'h0, 1, 2'd0);

        // Push and pop on different lanes together
        step(1, 2'd3, 32'h77, 0, 2'd0);
        step(1, 2'd1, 32'h88, 1, 2'd3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)), $urandom,
                 ($urandom_range(0, 99) < 45), 2'($urandom_range(0, 3)));
        end

        // Reset with lanes 0 and 2 non-empty
        step(1, 2'd0, 32'hC0, 0, 2'd0);
        step(1, 2'd2, 32'hC2, 0, 2'd0);
        mid_reset();
        step(0, 2'd0, 32'h0, 1, 2'd0);
        step(1, 2'd2, 32'hE2, 0, 2'd0);
        step(0, 2'd0, 32'h0, 1, 2'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
